// File: rtl/adc_monitor.sv
// ADC sample post-processing: power-of-two block averaging, scaling to display
// units with saturation, min/max tracking, display hold and a registered display mux.
module adc_monitor #(
    parameter int DATA_W       = 16,
    parameter int AVG_LOG2_MAX = 4,
    parameter int SCALE_MUL    = 278,
    parameter int SCALE_SHIFT  = 10,
    parameter int OUT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [2:0]        avg_log2,
    input  logic              hold,
    input  logic              clr_peak,
    input  logic [1:0]        disp_sel,
    output logic [OUT_W-1:0]  avg_out,
    output logic [OUT_W-1:0]  min_out,
    output logic [OUT_W-1:0]  max_out,
    output logic [OUT_W-1:0]  disp_out,
    output logic              out_valid,
    output logic              ovr
);

    localparam int ACC_W  = DATA_W + AVG_LOG2_MAX;
    localparam int CNT_W  = AVG_LOG2_MAX + 1;
    localparam int PROD_W = DATA_W + 32;

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_blk_l;
    logic [DATA_W-1:0] r_avg;
    logic              r_avg_vld;
    logic [DATA_W-1:0] r_raw;

    logic [2:0]        w_l_req;
    logic [2:0]        w_blk_l;
    logic              w_last;
    logic [ACC_W-1:0]  w_acc_sum;
    logic [DATA_W-1:0] w_avg_next;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_scaled_full;
    logic              w_sat;
    logic [OUT_W-1:0]  w_scaled;
    logic              w_update;
    logic [OUT_W-1:0]  w_raw_ext;
    logic [OUT_W-1:0]  w_disp_next;

    // The block length is taken from avg_log2 only on the first sample of a block.
    assign w_l_req    = ({29'd0, avg_log2} > AVG_LOG2_MAX) ? 3'(AVG_LOG2_MAX) : avg_log2;
    assign w_blk_l    = (r_cnt == '0) ? w_l_req : r_blk_l;
    assign w_last     = sample_valid && (r_cnt == ((CNT_W'(1) << w_blk_l) - CNT_W'(1)));
    assign w_acc_sum  = r_acc + ACC_W'(sample_in);
    assign w_avg_next = DATA_W'(w_acc_sum >> w_blk_l);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_blk_l   <= '0;
            r_avg     <= '0;
            r_avg_vld <= 1'b0;
            r_raw     <= '0;
        end else begin
            r_avg_vld <= w_last;
            if (w_last) begin
                r_avg <= w_avg_next;
            end
            if (sample_valid) begin
                if (r_cnt == '0) begin
                    r_blk_l <= w_l_req;
                end
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (!hold) begin
                    r_raw <= sample_in;
                end
            end
        end
    end

    assign w_prod        = PROD_W'(r_avg) * PROD_W'(SCALE_MUL);
    assign w_scaled_full = w_prod >> SCALE_SHIFT;
    assign w_sat         = |w_scaled_full[PROD_W-1:OUT_W];
    assign w_scaled      = w_sat ? '1 : w_scaled_full[OUT_W-1:0];
    assign w_update      = r_avg_vld && !hold;

    // A clear coincident with a new average lets that average seed both peaks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_out   <= '0;
            min_out   <= '1;
            max_out   <= '0;
            out_valid <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            out_valid <= w_update;
            ovr       <= (clr_peak ? 1'b0 : ovr) | (r_avg_vld & w_sat);
            if (w_update) begin
                avg_out <= w_scaled;
            end
            if (clr_peak && w_update) begin
                min_out <= w_scaled;
                max_out <= w_scaled;
            end else if (clr_peak) begin
                min_out <= '1;
                max_out <= '0;
            end else if (w_update) begin
                if (w_scaled < min_out) min_out <= w_scaled;
                if (w_scaled > max_out) max_out <= w_scaled;
            end
        end
    end

    assign w_raw_ext = OUT_W'(r_raw);

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_disp_next = avg_out;
        case (disp_sel)
            2'd1:    w_disp_next = min_out;
            2'd2:    w_disp_next = max_out;
            2'd3:    w_disp_next = w_raw_ext;
            default: w_disp_next = avg_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_out <= '0;
        end else begin
            disp_out <= w_disp_next;
        end
    end

endmodule

// File: tb/tb_adc_monitor.sv
// Directed bench for adc_monitor: default-width instance plus an OUT_W=10
// instance for the saturation case.
module tb_adc_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [2:0]  avg_log2;
    logic        hold;
    logic        clr_peak;
    logic [1:0]  disp_sel;
    logic [15:0] avg_out, min_out, max_out, disp_out;
    logic        out_valid, ovr;

    logic [15:0] n_sample_in;
    logic        n_sample_valid;
    logic [2:0]  n_avg_log2;
    logic        n_hold, n_clr_peak;
    logic [1:0]  n_disp_sel;
    logic [9:0]  n_avg_out, n_min_out, n_max_out, n_disp_out;
    logic        n_out_valid, n_ovr;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;

    always #5 clk = ~clk;

    adc_monitor dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .avg_log2(avg_log2), .hold(hold), .clr_peak(clr_peak), .disp_sel(disp_sel),
        .avg_out(avg_out), .min_out(min_out), .max_out(max_out), .disp_out(disp_out),
        .out_valid(out_valid), .ovr(ovr)
    );

    adc_monitor #(.OUT_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .sample_in(n_sample_in), .sample_valid(n_sample_valid),
        .avg_log2(n_avg_log2), .hold(n_hold), .clr_peak(n_clr_peak), .disp_sel(n_disp_sel),
        .avg_out(n_avg_out), .min_out(n_min_out), .max_out(n_max_out), .disp_out(n_disp_out),
        .out_valid(n_out_valid), .ovr(n_ovr)
    );

    always @(posedge clk) begin
        if (out_valid === 1'b1) pulses++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sample_in = '0; sample_valid = 1'b0; avg_log2 = 3'd2;
        hold = 1'b0; clr_peak = 1'b0; disp_sel = 2'd0;
        n_sample_in = '0; n_sample_valid = 1'b0; n_avg_log2 = 3'd0;
        n_hold = 1'b0; n_clr_peak = 1'b0; n_disp_sel = 2'd0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        check("rst_avg", avg_out, 0);
        check("rst_min", min_out, 16'hFFFF);
        check("rst_max", max_out, 0);
        check("rst_disp", disp_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ovr", ovr, 0);

        // L=2, four samples of 4096 -> 1112 two cycles after the last one
        sample_valid = 1'b1; sample_in = 16'd4096;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t1_no_early_pulse", out_valid, 0);
        end
        sample_valid = 1'b0;
        cyc();
        check("t1_valid", out_valid, 1);
        check("t1_avg", avg_out, 1112);
        cyc();
        check("t1_valid_one_cycle", out_valid, 0);
        check("t1_disp", disp_out, 1112);
        check("t1_min", min_out, 1112);
        check("t1_max", max_out, 1112);
        check("t1_ovr", ovr, 0);

        // L=0, averages 1000/3000/2000 after a peak clear
        avg_log2 = 3'd0;
        clr_peak = 1'b1;
        cyc();
        clr_peak = 1'b0;
        check("t2_clr_min", min_out, 16'hFFFF);
        check("t2_clr_max", max_out, 0);
        p0 = pulses;
        sample_valid = 1'b1;
        sample_in = 16'd1000; cyc();
        sample_in = 16'd3000; cyc();
        sample_in = 16'd2000; cyc();
        sample_valid = 1'b0;
        cyc(3);
        check("t2_pulses", pulses - p0, 3);
        check("t2_avg", avg_out, 542);
        check("t2_min", min_out, 271);
        check("t2_max", max_out, 814);
        disp_sel = 2'd1;
        cyc();
        check("t2_disp_min", disp_out, 271);

        // hold freezes results and raw capture while accumulation runs on
        hold = 1'b1; disp_sel = 2'd3;
        p0 = pulses;
        sample_valid = 1'b1; sample_in = 16'd100;
        cyc(8);
        sample_valid = 1'b0;
        cyc(3);
        check("t4_no_pulse", pulses - p0, 0);
        check("t4_avg", avg_out, 542);
        check("t4_min", min_out, 271);
        check("t4_max", max_out, 814);
        check("t4_raw_frozen", disp_out, 2000);
        hold = 1'b0;
        sample_valid = 1'b1; sample_in = 16'd4000;
        cyc();
        sample_valid = 1'b0;
        cyc(3);
        check("t4_release_pulse", pulses - p0, 1);
        check("t4_release_avg", avg_out, 1085);
        check("t4_release_max", max_out, 1085);
        check("t4_release_min", min_out, 271);
        check("t4_raw", disp_out, 4000);

        // avg_log2=7 clamps to 16; a mid-block change waits for the next block
        disp_sel = 2'd0; avg_log2 = 3'd7;
        p0 = pulses;
        sample_valid = 1'b1; sample_in = 16'd160;
        cyc(5);
        avg_log2 = 3'd1;
        cyc(10);
        sample_valid = 1'b0;
        cyc(3);
        check("t5_no_pulse_15", pulses - p0, 0);
        sample_valid = 1'b1;
        cyc();
        sample_valid = 1'b0;
        cyc(3);
        check("t5_pulse_16", pulses - p0, 1);
        check("t5_avg16", avg_out, 43);
        sample_valid = 1'b1; sample_in = 16'd1000;
        cyc();
        sample_valid = 1'b0;
        cyc(3);
        check("t5_no_pulse_1", pulses - p0, 1);
        sample_valid = 1'b1; sample_in = 16'd3000;
        cyc();
        sample_valid = 1'b0;
        cyc(3);
        check("t5_pulse_2", pulses - p0, 2);
        check("t5_avg2", avg_out, 542);

        // reset mid-block discards the partial sum
        avg_log2 = 3'd2;
        sample_valid = 1'b1; sample_in = 16'd4000;
        cyc(2);
        sample_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_avg", avg_out, 0);
        check("t6_rst_min", min_out, 16'hFFFF);
        check("t6_rst_max", max_out, 0);
        check("t6_rst_disp", disp_out, 0);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_ovr", ovr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sample_valid = 1'b1;
        sample_in = 16'd100; cyc();
        sample_in = 16'd200; cyc();
        sample_in = 16'd300; cyc();
        sample_in = 16'd400; cyc();
        sample_valid = 1'b0;
        cyc();
        check("t6_valid", out_valid, 1);
        check("t6_avg", avg_out, 67);
        check("t6_min", min_out, 67);
        check("t6_max", max_out, 67);

        // OUT_W=10 saturation and sticky overflow
        n_sample_valid = 1'b1; n_sample_in = 16'hFFFF;
        cyc();
        n_sample_valid = 1'b0;
        cyc();
        check("t3_valid", n_out_valid, 1);
        check("t3_avg_sat", n_avg_out, 1023);
        check("t3_ovr", n_ovr, 1);
        check("t3_min", n_min_out, 1023);
        check("t3_max", n_max_out, 1023);
        cyc();
        check("t3_ovr_sticky", n_ovr, 1);
        n_clr_peak = 1'b1;
        cyc();
        n_clr_peak = 1'b0;
        check("t3_clr_ovr", n_ovr, 0);
        check("t3_clr_min", n_min_out, 1023);
        check("t3_clr_max", n_max_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_monitor.md
Name: adc_monitor

Overview:
Parametrised post-processing stage for the XADC sample stream.
- Block-averages raw samples over a runtime-selectable power-of-two count.
- Scales each average to display units (e.g. mV) with saturation.
- Tracks min/max of averages, supports display hold, and presents a registered display value for the seven-segment driver and LEDs.
- Sits between the adc wrapper output and the display/LED logic in board top levels.

Parameters:
DATA_W, 16, raw sample width
AVG_LOG2_MAX, 4, largest supported log2 of block length (max 16 samples)
SCALE_MUL, 278, scale multiplier (4096 counts -> 1112)
SCALE_SHIFT, 10, right shift applied after multiply
OUT_W, 16, width of scaled outputs

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_in  in  DATA_W  raw ADC sample
sample_valid  in  1  sample_in valid this cycle
avg_log2  in  3  requested log2 block length
hold  in  1  freeze displayed/tracked values
clr_peak  in  1  pulse: reinitialise min/max
disp_sel  in  2  display select: 0 avg, 1 min, 2 max, 3 last raw sample (truncated/zero-extended to OUT_W)
avg_out  out  OUT_W  latest scaled average
min_out  out  OUT_W  minimum scaled average since clear
max_out  out  OUT_W  maximum scaled average since clear
disp_out  out  OUT_W  registered display value
out_valid  out  1  one-cycle pulse: new avg_out
ovr  out  1  sticky saturation flag

Behaviour:
Reset (async, rst_n low):
- accumulator, counter, avg_out, max_out, disp_out, out_valid, ovr = 0
- min_out = all ones
- Reset mid-block discards the partial block.

Block length N = 2^L:
- L = min(avg_log2, AVG_LOG2_MAX), latched when the first sample of a block is accepted.
- Changes to avg_log2 mid-block take effect at the next block.

Accumulator:
- Width DATA_W+AVG_LOG2_MAX; never overflows.
- Every sample_valid cycle adds sample_in.

Pipeline (no stall; samples are accepted every cycle):
- Cycle t: the Nth sample is accepted.
- Cycle t+1: avg register = acc >> L. Accumulator restarts; a sample valid at t+1 is the first of the next block.
- Cycle t+2: prod = avg*SCALE_MUL (full width), scaled = prod >> SCALE_SHIFT.
  - If scaled > 2^OUT_W-1: saturate to all ones and set ovr.
  - avg_out updates; out_valid pulses high for exactly one cycle.
- Latency: last sample to out_valid = 2 cycles.

hold = 1:
- avg_out, min_out, max_out frozen; out_valid suppressed.
- Accumulation continues.
- ovr still sets on saturation.

Min/max:
- Updated in the same cycle as avg_out, using the scaled value: min = smaller, max = larger.
- clr_peak: min <- all ones, max <- 0, ovr <- 0.
- clr_peak coincident with a new average: clear applies first, then that average loads into both min and max.

Display:
- disp_out is registered one cycle after the source changes.
- Mux is per disp_sel.
- Last raw sample register updates on every sample_valid unless hold.

Test Plan:
- L=2, four samples of 4096 -> out_valid 2 cycles after 4th sample, avg_out=1112; no pulse earlier.
- L=0, averages 1000, 3000, 2000 -> avg_out 271, 814, 542; min_out=271, max_out=814; disp_sel=1 -> disp_out=271 one cycle later.
- OUT_W=10, L=0, sample 0xFFFF -> avg_out=1023, ovr=1; clr_peak -> ovr=0, min=1023, max=0.
- hold=1 after first result, feed 8 more samples at L=0 -> avg_out/min/max unchanged, no out_valid; release -> next block updates.
- avg_log2=7 with AVG_LOG2_MAX=4 -> block of 16 samples; change avg_log2 to 1 mid-block -> current block still completes at 16 samples, next at 2.
- 2 samples into an L=2 block, pulse rst_n low -> all outputs at reset values immediately; next 4 samples produce a correct average.
